scr1_dmem_responder: RTL and testbench

//  Memory-side responder for the SCR1 DMEM request/response protocol: terminates one router port with word-organised RAM.

---
 rtl/scr1_dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_scr1_dmem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmem_responder.sv
// scr1_dmem_responder: memory-side terminator for one SCR1 DMEM port.
// Word-organised RAM behind a fixed-latency request/response FSM; illegal
// accesses (bad cmd/width, misalignment, out-of-range index) answer RDY_ER.
// Optional feature macro: SCR1_DMEM_RESP_STALL_EN (LFSR-driven random
// back-pressure on dmem_req_ack).

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

typedef enum logic [1:0] {
  SCR1_MEM_CMD_RD    = 2'b00,
  SCR1_MEM_CMD_WR    = 2'b01,
  SCR1_MEM_CMD_ERROR = 2'b11
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
  SCR1_MEM_WIDTH_BYTE  = 2'b00,
  SCR1_MEM_WIDTH_HWORD = 2'b01,
  SCR1_MEM_WIDTH_WORD  = 2'b10,
  SCR1_MEM_WIDTH_ERROR = 2'b11
} type_scr1_mem_width_e;

typedef enum logic [1:0] {
  SCR1_MEM_RESP_IDLE   = 2'b00,
  SCR1_MEM_RESP_RDY_OK = 2'b01,
  SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;

module scr1_dmem_responder #(
  parameter int unsigned SCR1_RESP_WORDS   = 1024,
  parameter int unsigned SCR1_RESP_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          dmem_req_ack,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata,
  output logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp
);

  localparam int unsigned AW = `SCR1_DMEM_AWIDTH;
  localparam int unsigned DW = `SCR1_DMEM_DWIDTH;
  localparam int unsigned IW = $clog2(SCR1_RESP_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(SCR1_RESP_LATENCY - 1);
  localparam logic [AW-1:0] WORDS_A = AW'(SCR1_RESP_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  type_scr1_mem_resp_e resp_q, resp_d;
  logic [DW-1:0]       rdata_q, rdata_d;

  logic [DW-1:0]       mem [SCR1_RESP_WORDS];

  logic [1:0]          off;
  logic [IW-1:0]       idx;
  logic                cmd_bad, wid_bad, mis, oor, req_err;
  logic [3:0]          be;
  logic [DW-1:0]       wdata_sh, rword, rd_sh;
  logic                stall_ok, accept, we;

  assign off      = dmem_addr[1:0];
  assign idx      = dmem_addr[IW+1:2];
  assign wdata_sh = dmem_wdata << {off, 3'b000};
  assign rword    = mem[idx];
  assign rd_sh    = rword >> {off, 3'b000};

  // Request decode: legality and byte enables of the presented request
  always_comb begin
    cmd_bad = !(dmem_cmd == SCR1_MEM_CMD_RD || dmem_cmd == SCR1_MEM_CMD_WR);
    wid_bad = 1'b0;
    mis     = 1'b0;
    be      = 4'b0000;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << off;
      SCR1_MEM_WIDTH_HWORD: begin be = 4'b0011 << off; mis = off[0]; end
      SCR1_MEM_WIDTH_WORD:  begin be = 4'b1111 << off; mis = (off != 2'b00); end
      default:              wid_bad = 1'b1;
    endcase
    // Index check uses the full address so high bits cannot alias into the array
    oor     = (dmem_addr >> 2) >= WORDS_A;
    req_err = cmd_bad | wid_bad | mis | oor;
  end

`ifdef SCR1_DMEM_RESP_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign stall_ok = lfsr_q[0];
  // Free-running back-pressure LFSR (x^8+x^6+x^5+x^4+1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign stall_ok = 1'b1;
`endif

  assign dmem_req_ack = !rst && (state_q != ST_WAIT) && stall_ok;
  assign accept       = dmem_req & dmem_req_ack;
  assign we           = accept && (dmem_cmd == SCR1_MEM_CMD_WR) && !req_err;

  // RAM write in the accept cycle, byte-lane granular; array is never reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Next state: latency countdown, capture of read data/error at accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
    // Accept only happens in IDLE/RESP, so it never collides with the countdown
    if (accept) begin
      err_d   = req_err;
      rdata_d = (req_err || dmem_cmd == SCR1_MEM_CMD_WR) ? '0 : rd_sh;
      cnt_d   = LAT_M1;
      state_d = (SCR1_RESP_LATENCY == 1) ? ST_RESP : ST_WAIT;
    end
    // Response is registered so it lines up with the RESP state
    resp_d = SCR1_MEM_RESP_IDLE;
    if (state_d == ST_RESP) resp_d = err_d ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
  end

  // State and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      resp_q  <= SCR1_MEM_RESP_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_resp  = resp_q;
  assign dmem_rdata = rdata_q;

endmodule

// File: tb/tb_scr1_dmem_responder.sv
// Directed bench for scr1_dmem_responder: a latency-1 and a latency-3 instance
// share the request bus; each has its own req/ack and response outputs.
module tb_scr1_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  type_scr1_mem_cmd_e   cmd;
  type_scr1_mem_width_e wid;
  logic [31:0] addr, wdata;
  logic req1, req3, ack1, ack3;
  logic [31:0] rdata1, rdata3;
  type_scr1_mem_resp_e resp1, resp3;

  int checks = 0, failures = 0, stalls = 0;

  always #5 clk = ~clk;

  scr1_dmem_responder #(.SCR1_RESP_WORDS(1024), .SCR1_RESP_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .dmem_req_ack(ack1), .dmem_req(req1), .dmem_cmd(cmd),
    .dmem_width(wid), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_rdata(rdata1), .dmem_resp(resp1));

  scr1_dmem_responder #(.SCR1_RESP_WORDS(1024), .SCR1_RESP_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .dmem_req_ack(ack3), .dmem_req(req3), .dmem_cmd(cmd),
    .dmem_width(wid), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_rdata(rdata3), .dmem_resp(resp3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                       input logic [31:0] a, input logic [31:0] d);
    cmd = c; wid = w; addr = a; wdata = d;
  endtask

  // Hold req1 until accepted; returns just after the accepting edge
  task automatic acc1(input string tag);
    int n;
    n = 0; req1 = 1'b1;
    while (ack1 !== 1'b1 && n < 64) begin stalls++; tick; n++; end
    chk({tag, " ack_timeout"}, 32'(n < 64), 32'd1);
    tick;
    req1 = 1'b0;
  endtask

  task automatic txn1(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                      input logic [31:0] a, input logic [31:0] d,
                      input type_scr1_mem_resp_e er, input logic [31:0] ed, input string tag);
    drive(c, w, a, d);
    acc1(tag);
    chk({tag, " resp"}, 32'(resp1), 32'(er));
    chk({tag, " rdata"}, rdata1, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  type_scr1_mem_cmd_e   t4c [4];
  type_scr1_mem_width_e t4w [4];
  logic [31:0] t4a [4], t4d [4], t4r [4];
  bit          accd [20];
  int          na, nr, wi, wsel, sz;
  bit          isw;
  logic [1:0]  off;
  logic [31:0] a, d, er;
  logic [31:0] tbm [16];
  type_scr1_mem_width_e w;

  initial begin
    rst = 1'b1; req1 = 1'b0; req3 = 1'b0;
    drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    repeat (3) tick;
    // Reset state
    chk("rst ack1", 32'(ack1), 32'd0);
    chk("rst ack3", 32'(ack3), 32'd0);
    chk("rst resp1", 32'(resp1), 32'(SCR1_MEM_RESP_IDLE));
    chk("rst resp3", 32'(resp3), 32'(SCR1_MEM_RESP_IDLE));
    chk("rst rdata1", rdata1, 32'h0);
    chk("rst rdata3", rdata3, 32'h0);
    rst = 1'b0;
    tick;

    // 1: WR then RD back-to-back at latency 1
`ifndef SCR1_DMEM_RESP_STALL_EN
    drive(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h100, 32'hDEADBEEF);
    req1 = 1'b1;
    chk("t1 ack wr", 32'(ack1), 32'd1);
    tick;
    chk("t1 resp wr", 32'(resp1), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("t1 rdata wr", rdata1, 32'h0);
    drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
    chk("t1 ack rd in RESP", 32'(ack1), 32'd1);
    tick;
    req1 = 1'b0;
    chk("t1 resp rd", 32'(resp1), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("t1 rdata rd", rdata1, 32'hDEADBEEF);
    tick;
    chk("t1 resp single cycle", 32'(resp1), 32'(SCR1_MEM_RESP_IDLE));
`else
    txn1(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h100, 32'hDEADBEEF, SCR1_MEM_RESP_RDY_OK, 32'h0, "t1 wr");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, "t1 rd");
`endif

    // 2: sub-word writes over DE AD BE EF -> byte3=11, bytes1:0=22 33 -> 0x11AD2233
    txn1(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h11, SCR1_MEM_RESP_RDY_OK, 32'h0, "t2 wrb");
    txn1(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h100, 32'h2233, SCR1_MEM_RESP_RDY_OK, 32'h0, "t2 wrh");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h11AD2233, "t2 rdw");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h00000011, "t2 rdb3");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h101, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h0011AD22, "t2 rdb1");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h102, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h000011AD, "t2 rdh2");

    // 3: illegal accesses; 0x1000 aliases word 0 if the range check were missing
    txn1(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0BADF00D, SCR1_MEM_RESP_RDY_OK, 32'h0, "t3 wr0");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h102, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0, "t3 rdw mis");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h101, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0, "t3 rdh mis");
    txn1(SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0, "t3 cmd err");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_ERROR, 32'h100, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0, "t3 wid err");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h1000, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0, "t3 rd oor");
    txn1(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h102, 32'hFFFFFFFF, SCR1_MEM_RESP_RDY_ER, 32'h0, "t3 wr mis");
    txn1(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h1000, 32'hFFFFFFFF, SCR1_MEM_RESP_RDY_ER, 32'h0, "t3 wr oor");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h11AD2233, "t3 rd100");
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h0BADF00D, "t3 rd0");

`ifndef SCR1_DMEM_RESP_STALL_EN
    // 4: latency 3 with req held: ack 1,0,0,1,... and a response 3 cycles after each accept
    t4c = '{SCR1_MEM_CMD_WR, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_WR, SCR1_MEM_CMD_RD};
    t4w = '{SCR1_MEM_WIDTH_WORD, SCR1_MEM_WIDTH_WORD, SCR1_MEM_WIDTH_WORD, SCR1_MEM_WIDTH_HWORD};
    t4a = '{32'h40, 32'h40, 32'h44, 32'h46};
    t4d = '{32'hA1B2C3D4, 32'h0, 32'h55667788, 32'h0};
    t4r = '{32'h0, 32'hA1B2C3D4, 32'h0, 32'h00005566};
    na = 0; nr = 0;
    for (int c = 0; c < 20; c++) begin
      if (c >= 3 && accd[c-3]) begin
        chk($sformatf("t4 resp c%0d", c), 32'(resp3), 32'(SCR1_MEM_RESP_RDY_OK));
        chk($sformatf("t4 rdata c%0d", c), rdata3, t4r[nr]);
        nr++;
      end else begin
        chk($sformatf("t4 idle c%0d", c), 32'(resp3), 32'(SCR1_MEM_RESP_IDLE));
      end
      if (na < 4) begin
        drive(t4c[na], t4w[na], t4a[na], t4d[na]);
        req3 = 1'b1;
        chk($sformatf("t4 ack c%0d", c), 32'(ack3), 32'((c % 3) == 0));
        accd[c] = ack3;
        if (ack3) na++;
      end else begin
        req3 = 1'b0;
        accd[c] = 1'b0;
      end
      tick;
    end
    chk("t4 accepts", 32'(na), 32'd4);
    chk("t4 responses", 32'(nr), 32'd4);

    // 5: reset while in WAIT drops the pending response
    drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, 32'h0);
    req3 = 1'b1;
    chk("t5 ack pre", 32'(ack3), 32'd1);
    tick;
    req3 = 1'b0;
    chk("t5 in wait ack", 32'(ack3), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5 ack1 in rst", 32'(ack1), 32'd0);
    tick;
    chk("t5 resp in rst", 32'(resp3), 32'(SCR1_MEM_RESP_IDLE));
    chk("t5 rdata in rst", rdata3, 32'h0);
    tick;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk($sformatf("t5 no late resp c%0d", c), 32'(resp3), 32'(SCR1_MEM_RESP_IDLE));
    end
    drive(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h44, 32'h0);
    req3 = 1'b1;
    chk("t5 first ack", 32'(ack3), 32'd1);
    tick;
    req3 = 1'b0;
    chk("t5 wait1", 32'(resp3), 32'(SCR1_MEM_RESP_IDLE));
    tick;
    chk("t5 wait2", 32'(resp3), 32'(SCR1_MEM_RESP_IDLE));
    tick;
    chk("t5 resp", 32'(resp3), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("t5 rdata", rdata3, 32'h55667788);
    txn1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h11AD2233, "t5 rd100");
`endif

    // 6: random legal traffic on a 16-word window against a byte-lane model
    for (int i = 0; i < 16; i++) begin
      tbm[i] = $urandom;
      txn1(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h200 + 32'(4*i), tbm[i],
           SCR1_MEM_RESP_RDY_OK, 32'h0, $sformatf("t6 init%0d", i));
    end
    for (int i = 0; i < 200; i++) begin
      wi   = $urandom_range(0, 15);
      wsel = $urandom_range(0, 2);
      isw  = 1'($urandom_range(0, 1));
      d    = $urandom;
      case (wsel)
        0:       begin w = SCR1_MEM_WIDTH_BYTE;  sz = 1; off = 2'($urandom_range(0, 3)); end
        1:       begin w = SCR1_MEM_WIDTH_HWORD; sz = 2; off = {1'($urandom_range(0, 1)), 1'b0}; end
        default: begin w = SCR1_MEM_WIDTH_WORD;  sz = 4; off = 2'b00; end
      endcase
      a = 32'h200 + 32'(4*wi) + 32'(off);
      if (isw) begin
        for (int b = 0; b < 4; b++)
          if (b >= int'(off) && b < int'(off) + sz) tbm[wi][8*b +: 8] = d[8*(b - int'(off)) +: 8];
        er = 32'h0;
      end else begin
        er = 32'h0;
        for (int b = int'(off); b < 4; b++) er[8*(b - int'(off)) +: 8] = tbm[wi][8*b +: 8];
      end
      txn1(isw ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD, w, a, d, SCR1_MEM_RESP_RDY_OK, er,
           $sformatf("t6 op%0d", i));
    end
`ifdef SCR1_DMEM_RESP_STALL_EN
    chk("t6 stall seen", 32'(stalls > 0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
